mskaes_round_scheduler: RTL

MSKAES_ROUND_SCHEDULER -- requirements
Module: mskaes_round_scheduler

---
 rtl/mskaes_round_scheduler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mskaes_round_scheduler.sv
// Round/phase sequencer for a masked AES-128 encryption datapath.
// Drives load, S-box injection, round-register writes and the key-schedule rcon.
module mskaes_round_scheduler #(
    parameter int unsigned LATENCY = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       load,
    output logic       sb_inject,
    output logic       rnd_req,
    output logic       state_we,
    output logic       last_round,
    output logic [3:0] round_idx,
    output logic [7:0] rcon,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t     r_state;
    state_t     w_state_nx;
    logic [3:0] r_round;
    logic [3:0] w_round_nx;
    logic [3:0] r_phase;
    logic [3:0] w_phase_nx;
    logic [7:0] r_rcon;
    logic [7:0] w_rcon_nx;

    logic       w_in_round;
    logic       w_ph_first;
    logic       w_ph_last;
    logic       w_rnd10;
    logic       w_load;
    logic [7:0] w_xtime;

    assign w_in_round = (r_state == S_ROUND);
    assign w_ph_first = (r_phase == 4'd0);
    assign w_ph_last  = (r_phase == LAT);
    assign w_rnd10    = (r_round == 4'd10);
    assign w_xtime    = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

    // Handshake and datapath strobes; every output is held low while in reset.
    assign in_ready   = nrst & (r_state == S_IDLE);
    assign w_load     = in_valid & in_ready & ~abort;
    assign load       = w_load;
    assign sb_inject  = nrst & w_in_round & w_ph_first;
    assign rnd_req    = sb_inject;
    assign state_we   = nrst & w_in_round & w_ph_last & ~abort;
    assign last_round = nrst & w_in_round & w_rnd10;
    assign out_valid  = nrst & (r_state == S_DONE) & ~abort;
    assign busy       = nrst & w_in_round;
    assign round_idx  = nrst ? r_round : 4'd0;
    assign rcon       = nrst ? r_rcon : 8'd0;

    // State, round, phase and rcon registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_round <= 4'd0;
            r_phase <= 4'd0;
            r_rcon  <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            r_round <= w_round_nx;
            r_phase <= w_phase_nx;
            r_rcon  <= w_rcon_nx;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_state_nx = r_state;
        w_round_nx = r_round;
        w_phase_nx = r_phase;
        w_rcon_nx  = r_rcon;
        unique case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nx = S_ROUND;
                    w_round_nx = 4'd1;
                    w_phase_nx = 4'd0;
                    w_rcon_nx  = 8'h01;
                end
            end
            S_ROUND: begin
                if (w_ph_last) begin
                    w_phase_nx = 4'd0;
                    if (w_rnd10) begin
                        w_state_nx = S_DONE;
                        w_round_nx = 4'd0;
                        w_rcon_nx  = 8'd0;
                    end else begin
                        w_round_nx = r_round + 4'd1;
                        w_rcon_nx  = w_xtime;
                    end
                end else begin
                    w_phase_nx = r_phase + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_round_nx = 4'd0;
                w_phase_nx = 4'd0;
                w_rcon_nx  = 8'd0;
            end
        endcase
        if (abort) begin
            w_state_nx = S_IDLE;
            w_round_nx = 4'd0;
            w_phase_nx = 4'd0;
            w_rcon_nx  = 8'd0;
        end
    end

endmodule
